fetch_unit_rv32i: RTL and testbench
===================================

# fetch_unit_rv32i

Instruction-fetch front end for the RV32I single-cycle core, directly upstream of `instr_rom_rv32i`. It owns the program counter and drives the ROM's `instr_addr`. It re-aligns the ROM's one-cycle registered read data with the PC that produced it. It presents a valid/stall-qualified instruction to decode and handles stalls, branch/jump redirects and misaligned-target faults.

## Interface
Parameters:
- `RESET_VECTOR`, default `32'h0000_0000`: PC loaded on reset; must be word-aligned.

Ports:
- `clock`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `instr_addr`, output, 32: registered PC, connected to the ROM `instr_addr`.
- `instr_in`, input, 32: ROM `instr_out`. Holds the word at the `instr_addr` sampled on the previous rising edge.
- `stall`, input, 1: decode cannot accept; hold the current instruction.
- `redirect_valid`, input, 1: taken branch or jump this cycle.
- `redirect_target`, input, 32: new PC when `redirect_valid` is high.
- `fetch_valid`, output, 1: `fetch_instr`/`fetch_pc` hold a real, correct-path instruction.
- `fetch_pc`, output, 32: address of `fetch_instr`.
- `fetch_instr`, output, 32: instruction to decode.
- `misalign_fault`, output, 1: sticky; a redirect target had `[1:0] != 0`.
- `fault_addr`, output, 32: the offending target. Captured once, when the fault first occurs.

## Operation
- State:
  - `pc` drives `instr_addr`.
  - `pc_q` drives `fetch_pc`.
  - `valid_q` drives `fetch_valid`.
  - `hold_valid` and `hold_instr` form the skid register.
  - `misalign_fault` and `fault_addr` are the fault registers.
- Reset values: `pc` = `pc_q` = `RESET_VECTOR`; `valid_q` = 0; `hold_valid` = 0; `hold_instr` = 0; `misalign_fault` = 0; `fault_addr` = 0.
- Output select: `fetch_instr` = `hold_valid ? hold_instr : instr_in`.
- Transfer: an instruction is consumed when `fetch_valid && !stall`.
- Per-edge priority, highest first (`reset` first):
  1. **Faulted** (`misalign_fault` = 1): `pc` and `pc_q` frozen; `valid_q` <= 0; `stall` and redirects ignored.
  2. **Misaligned redirect** (`redirect_valid` and `redirect_target[1:0] != 0`):
     - `misalign_fault` <= 1; `fault_addr` <= target.
     - `valid_q` <= 0; `hold_valid` <= 0; `pc` unchanged.
  3. **Redirect** (aligned; wins over `stall`):
     - `pc` <= target; `pc_q` <= `pc`.
     - `valid_q` <= 0, because the ROM sampled the wrong-path `pc`.
     - `hold_valid` <= 0.
  4. **Stall**:
     - `pc`, `pc_q` and `valid_q` hold.
     - If `hold_valid` = 0: `hold_instr` <= `instr_in`; `hold_valid` <= 1. Otherwise hold.
  5. **Advance**:
     - `pc_q` <= `pc`; `pc` <= `pc + 4`; `valid_q` <= 1; `hold_valid` <= 0.
- PC arithmetic: 32-bit modulo 2^32, so `0xFFFF_FFFC + 4` = `0x0000_0000`, with no flag.
- Under stall, the ROM keeps reading `pc`. On release, `instr_in` therefore already carries `instr[pc]`, which makes the skid register sufficient and adds no bubble.

## Timing
- ROM read latency is 1 cycle. Fetch-to-decode latency is 1 cycle after the PC is presented.
- First valid output appears in the cycle after the first rising edge with `reset` = 0: `fetch_pc` = `RESET_VECTOR`, `fetch_valid` = 1.
- Steady state: one instruction per cycle; `fetch_pc` steps by 4.
- Redirect penalty is exactly 1 bubble cycle:
  - Edge N (redirect high): the next cycle shows `fetch_valid` = 0.
  - Edge N+1: the cycle after shows `fetch_pc` = target with `fetch_valid` = 1.
- Stall: outputs are bit-stable for every stalled cycle. Release gives `fetch_pc + 4` on the next edge.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values on that edge; the skid contents are discarded.
- Redirect and stall in the same cycle: the redirect wins; the stalled instruction is dropped, as decode is flushed.

## Test plan
- **Reset/sequential:** `RESET_VECTOR` = 0, ROM word k = `0x1000_0000 + k`, release reset → `fetch_pc` 0, 4, 8, 0xC on successive cycles with `fetch_instr` `0x1000_0000..03`; `fetch_valid` = 0 in the first cycle.
- **Stall hold:** assert `stall` for 3 cycles while `fetch_pc` = 8 → `fetch_pc` = 8 and `fetch_instr` = `0x1000_0002` constant throughout; release → next cycle `fetch_pc` = 0xC, `fetch_instr` = `0x1000_0003`, no bubble.
- **Redirect:** `redirect_valid` with target `0x40` while `fetch_pc` = 4 → one cycle of `fetch_valid` = 0, then `fetch_pc` 0x40, 0x44 with words `0x1000_0010`, `0x1000_0011`. Repeat with `stall` = 1 in the same cycle → same result.
- **Misaligned:** redirect target `0x42` → `misalign_fault` = 1 and `fault_addr` = `0x42` next cycle; `fetch_valid` stays 0. A later aligned redirect to `0x80` changes nothing. `reset` clears the fault and restarts at `RESET_VECTOR`.
- **Wrap:** `RESET_VECTOR` = `0xFFFF_FFF8` → `fetch_pc` `0xFFFF_FFF8`, `0xFFFF_FFFC`, `0x0000_0000`, `0x0000_0004`.
- **Reset mid-stall:** stall at `fetch_pc` = 0xC with the skid loaded, then assert `reset` for 1 cycle → next cycle `fetch_valid` = 0 and `instr_addr` = `RESET_VECTOR`; the stale skid word never reappears.

Source files
------------

// File: rtl/fetch_unit_rv32i_if.sv
// Fetch-unit bus bundle: ROM address/data, decode handshake, redirect and fault status.
interface fetch_unit_rv32i_if;
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] instr_addr;
  logic [XLEN-1:0] instr_in;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_instr;
  logic            misalign_fault;
  logic [XLEN-1:0] fault_addr;

  modport master (
    output instr_addr, fetch_valid, fetch_pc, fetch_instr, misalign_fault, fault_addr,
    input  instr_in, stall, redirect_valid, redirect_target
  );

  modport slave (
    input  instr_addr, fetch_valid, fetch_pc, fetch_instr, misalign_fault, fault_addr,
    output instr_in, stall, redirect_valid, redirect_target
  );
endinterface

// File: rtl/fetch_unit_rv32i.sv
// RV32I instruction fetch: owns the PC, re-aligns 1-cycle ROM data with its PC,
// and handles stall (via a one-entry skid), redirects and misaligned-target faults.
module fetch_unit_rv32i #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                clock,
  input  logic                reset,
  fetch_unit_rv32i_if.master  bus
);
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            valid_q, valid_d;
  logic            hold_valid_q, hold_valid_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;
  logic            misaligned_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q       <= RESET_VECTOR;
      fetch_pc_q   <= RESET_VECTOR;
      valid_q      <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      addr_q       <= addr_d;
      fetch_pc_q   <= fetch_pc_d;
      valid_q      <= valid_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // Priority: fault freeze > misaligned redirect > redirect > stall > advance
  always_comb begin
    addr_d       = addr_q;
    fetch_pc_d   = fetch_pc_q;
    valid_d      = valid_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    misaligned_c = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);

    if (fault_q) begin
      valid_d = 1'b0;
    end else if (misaligned_c) begin
      fault_d      = 1'b1;
      fault_addr_d = bus.redirect_target;
      valid_d      = 1'b0;
      hold_valid_d = 1'b0;
    end else if (bus.redirect_valid) begin
      // ROM already sampled the wrong-path PC, so the next cycle is a bubble
      addr_d       = bus.redirect_target;
      fetch_pc_d   = addr_q;
      valid_d      = 1'b0;
      hold_valid_d = 1'b0;
    end else if (bus.stall) begin
      // Capture the word once; the ROM then moves on to instr[addr_q]
      if (!hold_valid_q) begin
        hold_instr_d = bus.instr_in;
        hold_valid_d = 1'b1;
      end
    end else begin
      fetch_pc_d   = addr_q;
      addr_d       = addr_q + XLEN'(4);
      valid_d      = 1'b1;
      hold_valid_d = 1'b0;
    end
  end

  assign bus.instr_addr     = addr_q;
  assign bus.fetch_pc       = fetch_pc_q;
  assign bus.fetch_valid    = valid_q;
  assign bus.fetch_instr    = hold_valid_q ? hold_instr_q : bus.instr_in;
  assign bus.misalign_fault = fault_q;
  assign bus.fault_addr     = fault_addr_q;
endmodule

// File: tb/tb_fetch_unit_rv32i.sv
// Bench for fetch_unit_rv32i: directed scenarios plus randomized stall/redirect/reset
// traffic checked against a behavioural model where fetch_instr must equal ROM[fetch_pc].
module tb_fetch_unit_rv32i;
  logic clock = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  fetch_unit_rv32i_if ifa ();
  fetch_unit_rv32i_if ifb ();

  fetch_unit_rv32i #(.RESET_VECTOR(32'h0000_0000)) dut_a (.clock(clock), .reset(rst_a), .bus(ifa));
  fetch_unit_rv32i #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_b (.clock(clock), .reset(rst_b), .bus(ifb));

  // ROM: word k holds 0x1000_0000 + k, one-cycle registered read
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  always @(posedge clock) begin
    ifa.instr_in <= word(ifa.instr_addr);
    ifb.instr_in <= word(ifb.instr_addr);
  end

  // Reference model: ROM address, presented PC/valid, fault status
  logic [31:0] m_addr, m_fpc, m_faddr;
  logic        m_valid, m_fault;

  task automatic model_step(input logic r, input logic st, input logic rv, input logic [31:0] tgt);
    if (r) begin
      m_addr = 32'h0; m_fpc = 32'h0; m_valid = 1'b0; m_fault = 1'b0; m_faddr = 32'h0;
    end else if (m_fault) begin
      m_valid = 1'b0;
    end else if (rv && (tgt % 4 != 0)) begin
      m_fault = 1'b1; m_faddr = tgt; m_valid = 1'b0;
    end else if (rv) begin
      m_fpc = m_addr; m_addr = tgt; m_valid = 1'b0;
    end else if (!st) begin
      m_fpc = m_addr; m_addr = m_addr + 32'd4; m_valid = 1'b1;
    end
  endtask

  task automatic tick(input logic r, input logic st, input logic rv, input logic [31:0] tgt);
    rst_a = r; ifa.stall = st; ifa.redirect_valid = rv; ifa.redirect_target = tgt;
    model_step(r, st, rv, tgt);
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({ifa.fetch_valid, ifa.instr_addr, ifa.fetch_pc, ifa.misalign_fault, ifa.fault_addr}
        !== {1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state got v=%b addr=%h pc=%h f=%b fa=%h", ifa.fetch_valid,
               ifa.instr_addr, ifa.fetch_pc, ifa.misalign_fault, ifa.fault_addr);
    end
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if ({ifa.fetch_valid, ifa.fetch_pc, ifa.fetch_instr} !== {1'b1, 32'(4 * k), 32'h1000_0000 + 32'(k)}) begin
        errors++;
        $display("FAIL seq_%0d got v=%b pc=%h ins=%h exp pc=%h ins=%h", k, ifa.fetch_valid,
                 ifa.fetch_pc, ifa.fetch_instr, 32'(4 * k), 32'h1000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_stall_hold;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      checks++;
      if ({ifa.fetch_valid, ifa.fetch_pc, ifa.fetch_instr} !== {1'b1, 32'h8, 32'h1000_0002}) begin
        errors++;
        $display("FAIL stall_hold_%0d got v=%b pc=%h ins=%h exp pc=8 ins=10000002", k,
                 ifa.fetch_valid, ifa.fetch_pc, ifa.fetch_instr);
      end
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({ifa.fetch_valid, ifa.fetch_pc, ifa.fetch_instr} !== {1'b1, 32'hC, 32'h1000_0003}) begin
      errors++;
      $display("FAIL stall_release got v=%b pc=%h ins=%h exp pc=c ins=10000003",
               ifa.fetch_valid, ifa.fetch_pc, ifa.fetch_instr);
    end
  endtask

  task automatic test_redirect(input logic st);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, st, 1'b1, 32'h40);
    checks++;
    if (ifa.fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_bubble st=%b got v=%b exp 0", st, ifa.fetch_valid);
    end
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if ({ifa.fetch_valid, ifa.fetch_pc, ifa.fetch_instr}
          !== {1'b1, 32'h40 + 32'(4 * k), 32'h1000_0010 + 32'(k)}) begin
        errors++;
        $display("FAIL redirect_seq_%0d st=%b got v=%b pc=%h ins=%h", k, st,
                 ifa.fetch_valid, ifa.fetch_pc, ifa.fetch_instr);
      end
    end
  endtask

  task automatic test_misaligned;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 32'h42);
    checks++;
    if ({ifa.misalign_fault, ifa.fault_addr, ifa.fetch_valid, ifa.instr_addr} !== {1'b1, 32'h42, 1'b0, 32'h8}) begin
      errors++;
      $display("FAIL misalign_set got f=%b fa=%h v=%b addr=%h exp 1 42 0 8",
               ifa.misalign_fault, ifa.fault_addr, ifa.fetch_valid, ifa.instr_addr);
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 32'h80);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({ifa.misalign_fault, ifa.fault_addr, ifa.fetch_valid, ifa.instr_addr, ifa.fetch_pc}
        !== {1'b1, 32'h42, 1'b0, 32'h8, 32'h4}) begin
      errors++;
      $display("FAIL misalign_frozen got f=%b fa=%h v=%b addr=%h pc=%h", ifa.misalign_fault,
               ifa.fault_addr, ifa.fetch_valid, ifa.instr_addr, ifa.fetch_pc);
    end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({ifa.misalign_fault, ifa.fault_addr, ifa.fetch_valid, ifa.instr_addr} !== {1'b0, 32'h0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL misalign_clear got f=%b fa=%h v=%b addr=%h", ifa.misalign_fault,
               ifa.fault_addr, ifa.fetch_valid, ifa.instr_addr);
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({ifa.fetch_valid, ifa.fetch_pc, ifa.fetch_instr} !== {1'b1, 32'h0, 32'h1000_0000}) begin
      errors++;
      $display("FAIL misalign_restart got v=%b pc=%h ins=%h", ifa.fetch_valid, ifa.fetch_pc, ifa.fetch_instr);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] pc;
    ifb.stall = 1'b0; ifb.redirect_valid = 1'b0; ifb.redirect_target = 32'h0;
    rst_b = 1'b1;
    @(posedge clock); #2;
    rst_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #2;
      pc = 32'hFFFF_FFF8 + 32'(4 * k);
      checks++;
      if ({ifb.fetch_valid, ifb.fetch_pc, ifb.fetch_instr} !== {1'b1, pc, word(pc)}) begin
        errors++;
        $display("FAIL wrap_%0d got v=%b pc=%h ins=%h exp pc=%h ins=%h", k, ifb.fetch_valid,
                 ifb.fetch_pc, ifb.fetch_instr, pc, word(pc));
      end
    end
  endtask

  task automatic test_reset_mid_stall;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({ifa.fetch_valid, ifa.fetch_pc, ifa.fetch_instr} !== {1'b1, 32'hC, 32'h1000_0003}) begin
      errors++;
      $display("FAIL midstall_hold got v=%b pc=%h ins=%h", ifa.fetch_valid, ifa.fetch_pc, ifa.fetch_instr);
    end
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({ifa.fetch_valid, ifa.instr_addr, ifa.fetch_pc} !== {1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL midstall_reset got v=%b addr=%h pc=%h", ifa.fetch_valid, ifa.instr_addr, ifa.fetch_pc);
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({ifa.fetch_valid, ifa.fetch_pc, ifa.fetch_instr} !== {1'b1, 32'h0, 32'h1000_0000}) begin
      errors++;
      $display("FAIL midstall_restart got v=%b pc=%h ins=%h", ifa.fetch_valid, ifa.fetch_pc, ifa.fetch_instr);
    end
  endtask

  task automatic test_random;
    logic        r, st, rv;
    logic [31:0] t;
    logic [160:0] act, exp;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 30);
      rv = ($urandom_range(0, 99) < 15);
      t  = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 99) < 4) t[1:0] = 2'($urandom_range(1, 3));
      tick(r, st, rv, t);
      exp = {m_valid, m_fault, m_faddr, m_addr, m_fpc, m_valid ? word(m_fpc) : 32'h0};
      act = {ifa.fetch_valid, ifa.misalign_fault, ifa.fault_addr, ifa.instr_addr, ifa.fetch_pc,
             ifa.fetch_valid ? ifa.fetch_instr : 32'h0};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL random_%0d got %h exp %h", n, act, exp);
      end
    end
  endtask

  initial begin
    rst_b = 1'b1;
    ifb.stall = 1'b0; ifb.redirect_valid = 1'b0; ifb.redirect_target = 32'h0;
    test_reset();
    test_stall_hold();
    test_redirect(1'b0);
    test_redirect(1'b1);
    test_misaligned();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
